tensor_mma_sched: RTL and testbench
===================================

Name: tensor_mma_sched

Overview:
- Warp-level scheduler in front of the tensor PE array.
- Arbitrates MMA requests from NUM_WARPS warps round-robin and latches the granted request.
- Sequences the request into NUM_STEPS per-step issue beats on a valid/ready PE port, driving wid, step, tile, acc_src, wb and rd.
- Blocks a warp from re-issuing while its previous MMA result is still outstanding.

Parameters:
NUM_WARPS, 4, number of requesting warps (power of 2, >=2)
NUM_TILES, 2, accumulator tiles per warp (power of 2, >=2)
NUM_STEPS, 4, issue beats per MMA (power of 2, >=2)
WIDW = $clog2(NUM_WARPS), TILEW = $clog2(NUM_TILES), STEPW = $clog2(NUM_STEPS) (localparams)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_WARPS  per-warp MMA request
req_ready  out  NUM_WARPS  per-warp grant, one-hot or zero
req_tile  in  NUM_WARPS*TILEW  per-warp accumulator tile select, warp w at [w*TILEW +: TILEW]
req_acc_zero  in  NUM_WARPS  per-warp flag: start the accumulation from zero
req_wb  in  NUM_WARPS  per-warp flag: write the result to a register rather than a tile
req_rd  in  NUM_WARPS*5  per-warp destination register
pe_valid  out  1  issue beat valid
pe_ready  in  1  PE accepts beat
pe_wid  out  WIDW  warp of the beat
pe_step  out  STEPW  step index, 0..NUM_STEPS-1
pe_tile  out  TILEW  tile of the beat
pe_acc_src  out  acc_src_t  ACC_SRC_ZERO or ACC_SRC_REG
pe_wb  out  1  register writeback; set on the last beat only
pe_rd  out  5  destination register
rsp_valid  in  1  PE reports an MMA complete
rsp_wid  in  WIDW  warp of the completed MMA
warp_pending  out  NUM_WARPS  MMA issued and not yet completed, per warp
rsp_err  out  1  sticky: a response arrived for a non-pending warp

Behaviour:
- Reset (async on reset_n low, any state, including mid-sequence): FSM enters IDLE, step=0, rr_ptr=0, warp_pending=0, rsp_err=0, latched fields=0.
- Reset outputs: req_ready=0, pe_valid=0, pe_* = 0, pe_acc_src = ACC_SRC_ZERO.
- eligible[w] = req_valid[w] & ~warp_pending[w].
- State IDLE:
  - If any eligible, grant the first eligible index searching from rr_ptr upward with wrap.
  - req_ready[g]=1 combinationally in that cycle only.
  - Latch tile/acc_zero/wb/rd of warp g and wid=g; step=0; go to ISSUE.
  - No eligible warp: stay in IDLE, req_ready=0.
- State ISSUE:
  - pe_valid=1.
  - pe_wid, pe_tile and pe_rd come from the latched request; pe_step=step.
  - pe_acc_src = ACC_SRC_ZERO when step==0 and acc_zero=1, otherwise ACC_SRC_REG.
  - pe_wb = wb & (step==NUM_STEPS-1).
  - Outputs stay stable while pe_ready=0; the FSM holds.
  - On pe_valid & pe_ready with step<NUM_STEPS-1: step increments.
  - On pe_valid & pe_ready with step==NUM_STEPS-1: set warp_pending[wid], rr_ptr = wid+1 (wraps via WIDW truncation), step=0, go to IDLE.
- req_ready is always 0 in ISSUE.
- Latency: grant in cycle G; beats in G+1..G+NUM_STEPS with pe_ready held high; IDLE at G+NUM_STEPS+1, where the next grant can occur. Throughput is one MMA per NUM_STEPS+1 cycles.
- rsp_valid:
  - Clears warp_pending[rsp_wid] on the next clock edge.
  - If warp_pending[rsp_wid]==0, set rsp_err (sticky until reset); pending is unchanged.
  - Clear and the last-beat set on the same warp in the same cycle cannot legally occur. If it does, the set wins and rsp_err is set.
- A clear for warp w in cycle t makes w eligible from cycle t+1. There is no combinational path from rsp_valid to req_ready.
- A requester drops req_valid only after it sees req_ready. Deassertion without a grant is allowed and is ignored.

Decomposition:
- acc_src_t (ACC_SRC_ZERO, ACC_SRC_REG) lives in the shared tensor package, together with the rd width constant 5.
- The FSM state enum is local to this module.
- The round-robin priority picker is a natural sub-module, tensor_rr_arbiter: inputs eligible and rr_ptr; outputs a one-hot grant plus a grant index and a valid flag. It is purely combinational; rr_ptr is held in the scheduler.

Test Plan:
- Reset mid-ISSUE: warp 1 at step 2, then reset_n=0 → next cycle pe_valid=0, warp_pending=0, FSM in IDLE. After release, warp 1 re-request is granted.
- Single MMA: req_valid=4'b0001, tile=1, acc_zero=1, wb=1, rd=7, pe_ready=1 → req_ready[0] in cycle 0. Beats in cycles 1-4 with steps 0..3. acc_src is ZERO only on step 0. pe_wb only on step 3 with rd=7. warp_pending=4'b0001 from cycle 5.
- Round-robin: all four warps request continuously, with rsp returned 1 cycle after each last beat → grant order 0,1,2,3,0; grants 5 cycles apart.
- Backpressure: pe_ready low for 3 cycles at step 1 → pe_step holds at 1 and all pe_* are stable. The sequence completes 3 cycles later than the no-stall case.
- Pending block: warp 2 pending and re-requesting while warp 3 is idle → warp 2 is never granted. rsp_valid with rsp_wid=2 → warp 2 is granted at the next IDLE after the clear.
- Spurious response: rsp_wid=3 with no pending MMA → rsp_err=1 and stays 1; warp_pending is unchanged.

Source files
------------

// File: rtl/tensor_mma_sched_pkg.sv
// Types and constants shared by the tensor MMA scheduler and the PE array interface.
package tensor_mma_sched_pkg;

  localparam int RD_W = 5;

  typedef enum logic {
    ACC_SRC_ZERO = 1'b0,
    ACC_SRC_REG  = 1'b1
  } acc_src_t;

endpackage

// File: rtl/tensor_mma_sched_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after i_rr_ptr, with wrap.
module tensor_rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_eligible,
  input  logic [W-1:0] i_rr_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin
    logic [W-1:0] cand;
    // NOTE: every output gets a default before the search, so no path leaves one unassigned (no latch).
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = i_rr_ptr + W'(i);
      if (!o_valid && i_eligible[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
    if (o_valid) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/tensor_mma_sched.sv
// Warp-level MMA scheduler: round-robin grant, NUM_STEPS issue beats to the PE, per-warp pending tracking.
module tensor_mma_sched
  import tensor_mma_sched_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int NUM_TILES = 2,
  parameter  int NUM_STEPS = 4,
  localparam int WIDW      = $clog2(NUM_WARPS),
  localparam int TILEW     = $clog2(NUM_TILES),
  localparam int STEPW     = $clog2(NUM_STEPS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_WARPS-1:0]       req_valid,
  output logic [NUM_WARPS-1:0]       req_ready,
  input  logic [NUM_WARPS*TILEW-1:0] req_tile,
  input  logic [NUM_WARPS-1:0]       req_acc_zero,
  input  logic [NUM_WARPS-1:0]       req_wb,
  input  logic [NUM_WARPS*RD_W-1:0]  req_rd,
  output logic                       pe_valid,
  input  logic                       pe_ready,
  output logic [WIDW-1:0]            pe_wid,
  output logic [STEPW-1:0]           pe_step,
  output logic [TILEW-1:0]           pe_tile,
  output acc_src_t                   pe_acc_src,
  output logic                       pe_wb,
  output logic [RD_W-1:0]            pe_rd,
  input  logic                       rsp_valid,
  input  logic [WIDW-1:0]            rsp_wid,
  output logic [NUM_WARPS-1:0]       warp_pending,
  output logic                       rsp_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NUM_STEPS - 1);

  state_t               r_state;
  logic [STEPW-1:0]     r_step;
  logic [WIDW-1:0]      r_rr_ptr;
  logic [WIDW-1:0]      r_wid;
  logic [TILEW-1:0]     r_tile;
  logic                 r_acc_zero;
  logic                 r_wb;
  logic [RD_W-1:0]      r_rd;
  logic [NUM_WARPS-1:0] r_pending;
  logic                 r_rsp_err;

  logic [NUM_WARPS-1:0] w_eligible;
  logic [NUM_WARPS-1:0] w_grant;
  logic [WIDW-1:0]      w_gnt_idx;
  logic                 w_gnt_valid;
  logic                 w_issue;
  logic                 w_last;
  logic [NUM_WARPS-1:0] w_pending_nxt;
  logic                 w_err_nxt;

  assign w_eligible = req_valid & ~r_pending;

  tensor_rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_gnt_idx),
    .o_valid    (w_gnt_valid)
  );

  assign w_issue   = (r_state == S_ISSUE);
  assign w_last    = w_issue && pe_ready && (r_step == LAST_STEP);
  assign req_ready = (r_state == S_IDLE) ? w_grant : '0;

  // A response racing the last beat of the same warp is illegal: the set wins and it is flagged.
  always_comb begin
    w_pending_nxt = r_pending;
    w_err_nxt     = r_rsp_err;
    if (rsp_valid) begin
      if (!r_pending[rsp_wid] || (w_last && (rsp_wid == r_wid))) w_err_nxt = 1'b1;
      w_pending_nxt[rsp_wid] = 1'b0;
    end
    if (w_last) w_pending_nxt[r_wid] = 1'b1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_rr_ptr   <= '0;
      r_wid      <= '0;
      r_tile     <= '0;
      r_acc_zero <= 1'b0;
      r_wb       <= 1'b0;
      r_rd       <= '0;
      r_pending  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_rsp_err <= w_err_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_wid      <= w_gnt_idx;
            r_tile     <= req_tile[w_gnt_idx*TILEW +: TILEW];
            r_acc_zero <= req_acc_zero[w_gnt_idx];
            r_wb       <= req_wb[w_gnt_idx];
            r_rd       <= req_rd[w_gnt_idx*RD_W +: RD_W];
            r_step     <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pe_ready) begin
            if (r_step == LAST_STEP) begin
              r_step   <= '0;
              r_rr_ptr <= r_wid + 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // PE fields are forced to zero outside ISSUE so the port idles at its reset values.
  assign pe_valid     = w_issue;
  assign pe_wid       = w_issue ? r_wid  : '0;
  assign pe_step      = w_issue ? r_step : '0;
  assign pe_tile      = w_issue ? r_tile : '0;
  assign pe_rd        = w_issue ? r_rd   : '0;
  assign pe_wb        = w_issue && r_wb && (r_step == LAST_STEP);
  assign pe_acc_src   = (w_issue && !((r_step == '0) && r_acc_zero)) ? ACC_SRC_REG : ACC_SRC_ZERO;
  assign warp_pending = r_pending;
  assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_tensor_mma_sched.sv
// Directed bench for tensor_mma_sched: reset, single MMA, round-robin, backpressure, pending block, spurious response.
module tb_tensor_mma_sched;
  import tensor_mma_sched_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_tile;
  logic [3:0]  req_acc_zero;
  logic [3:0]  req_wb;
  logic [19:0] req_rd;
  logic        pe_valid;
  logic        pe_ready;
  logic [1:0]  pe_wid;
  logic [1:0]  pe_step;
  logic [0:0]  pe_tile;
  acc_src_t    pe_acc_src;
  logic        pe_wb;
  logic [4:0]  pe_rd;
  logic        rsp_valid;
  logic [1:0]  rsp_wid;
  logic [3:0]  warp_pending;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  tensor_mma_sched dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_tile     (req_tile),
    .req_acc_zero (req_acc_zero),
    .req_wb       (req_wb),
    .req_rd       (req_rd),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .pe_wid       (pe_wid),
    .pe_step      (pe_step),
    .pe_tile      (pe_tile),
    .pe_acc_src   (pe_acc_src),
    .pe_wb        (pe_wb),
    .pe_rd        (pe_rd),
    .rsp_valid    (rsp_valid),
    .rsp_wid      (rsp_wid),
    .warp_pending (warp_pending),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int w, input logic tile, input logic acc_zero,
                         input logic wb, input logic [4:0] rd);
    req_tile[w]        = tile;
    req_acc_zero[w]    = acc_zero;
    req_wb[w]          = wb;
    req_rd[w*5 +: 5]   = rd;
  endtask

  int rr_order [5] = '{0, 1, 2, 3, 0};
  int g_cyc;
  int n;

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_tile     = '0;
    req_acc_zero = '0;
    req_wb       = '0;
    req_rd       = '0;
    pe_ready     = 1'b0;
    rsp_valid    = 1'b0;
    rsp_wid      = '0;

    // Reset state
    tick(); tick();
    check("rst_pe_valid", pe_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_pending", warp_pending, 0);
    check("rst_err", rsp_err, 0);
    check("rst_acc_src", pe_acc_src, ACC_SRC_ZERO);
    check("rst_pe_fields", {pe_wid, pe_step, pe_tile, pe_wb, pe_rd}, 0);
    reset_n = 1'b1;
    tick();

    // Single MMA on warp 0
    set_req(0, 1'b1, 1'b1, 1'b1, 5'd7);
    req_valid = 4'b0001;
    pe_ready  = 1'b1;
    #1;
    check("single_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int s = 0; s < 4; s++) begin
      #1;
      check("single_valid", pe_valid, 1);
      check("single_step", pe_step, s);
      check("single_wid_tile_rd", {pe_wid, pe_tile, pe_rd}, {2'd0, 1'b1, 5'd7});
      check("single_acc_src", pe_acc_src, (s == 0) ? ACC_SRC_ZERO : ACC_SRC_REG);
      check("single_wb", pe_wb, (s == 3));
      check("single_ready_low", req_ready, 0);
      tick();
    end
    check("single_idle", pe_valid, 0);
    check("single_pending", warp_pending, 4'b0001);

    // Reset in the middle of an ISSUE sequence on warp 1
    set_req(1, 1'b0, 1'b0, 1'b0, 5'd3);
    req_valid = 4'b0010;
    #1;
    check("midrst_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick(); tick();
    check("midrst_step2", {pe_valid, pe_wid, pe_step}, {1'b1, 2'd1, 2'd2});
    reset_n = 1'b0;
    #1;
    check("midrst_async_valid", pe_valid, 0);
    check("midrst_pending", warp_pending, 0);
    tick();
    check("midrst_next_valid", pe_valid, 0);
    reset_n   = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("midrst_regrant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    check("midrst_reissue", {pe_valid, pe_wid, pe_step}, {1'b1, 2'd1, 2'd0});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Round-robin with all four warps requesting; response one cycle after each last beat
    for (int w = 0; w < 4; w++) set_req(w, w[0], 1'b0, 1'b0, 5'(10 + w));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == 0 && n < 20) begin
        tick();
        n++;
      end
      check("rr_wait_bound", (n < 20), 1);
      check("rr_grant", req_ready, 1 << rr_order[k]);
      if (k > 0) begin
        check("rr_gap", cyc - g_cyc, 5);
        rsp_valid = 1'b1;
        rsp_wid   = 2'(rr_order[k-1]);
      end
      g_cyc = cyc;
      tick();
      rsp_valid = 1'b0;
      if (k == 4) req_valid = '0;
      #1;
      check("rr_beat", {pe_valid, pe_wid, pe_step, pe_tile},
            {1'b1, 2'(rr_order[k]), 2'd0, 1'(rr_order[k] & 1)});
      check("rr_rd", pe_rd, 10 + rr_order[k]);
      tick(); tick(); tick(); tick();
    end
    check("rr_end_idle", pe_valid, 0);
    check("rr_end_pending", warp_pending, 4'b0001);
    rsp_valid = 1'b1;
    rsp_wid   = 2'd0;
    tick();
    rsp_valid = 1'b0;
    check("rr_clear", warp_pending, 0);
    check("rr_no_err", rsp_err, 0);

    // Backpressure: pe_ready low for 3 cycles at step 1
    set_req(2, 1'b0, 1'b1, 1'b1, 5'd9);
    req_valid = 4'b0100;
    #1;
    check("bp_grant", req_ready, 4'b0100);
    g_cyc = cyc;
    tick();
    req_valid = '0;
    check("bp_step0_acc", pe_acc_src, ACC_SRC_ZERO);
    tick();
    pe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold", {pe_valid, pe_wid, pe_step, pe_tile, pe_wb, pe_rd},
            {1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 5'd9});
      check("bp_hold_acc", pe_acc_src, ACC_SRC_REG);
      tick();
    end
    pe_ready = 1'b1;
    #1;
    check("bp_still_step1", pe_step, 1);
    tick();
    check("bp_step2", pe_step, 2);
    tick();
    check("bp_step3_wb", {pe_step, pe_wb, pe_rd}, {2'd3, 1'b1, 5'd9});
    n = 0;
    while (pe_valid && n < 10) begin
      tick();
      n++;
    end
    check("bp_done_bound", (n < 10), 1);
    check("bp_latency", cyc - g_cyc, 8);
    check("bp_pending", warp_pending, 4'b0100);

    // Pending block: warp 2 re-requests while its MMA is outstanding
    req_valid = 4'b0100;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("blk_no_grant", {req_ready, pe_valid}, 0);
      tick();
    end
    rsp_valid = 1'b1;
    rsp_wid   = 2'd2;
    #1;
    check("blk_no_comb_path", req_ready, 0);
    tick();
    rsp_valid = 1'b0;
    #1;
    check("blk_cleared", warp_pending, 0);
    check("blk_grant_after_clear", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("blk_issue", {pe_valid, pe_wid}, {1'b1, 2'd2});
    tick(); tick(); tick(); tick();
    check("blk_done", {pe_valid, warp_pending}, {1'b0, 4'b0100});

    // Spurious response for a warp with nothing outstanding
    rsp_valid = 1'b1;
    rsp_wid   = 2'd3;
    tick();
    rsp_valid = 1'b0;
    check("spur_err", rsp_err, 1);
    check("spur_pending", warp_pending, 4'b0100);
    tick(); tick();
    check("spur_sticky", rsp_err, 1);
    rsp_valid = 1'b1;
    rsp_wid   = 2'd2;
    tick();
    rsp_valid = 1'b0;
    check("spur_legal_clear", {warp_pending, rsp_err}, {4'b0000, 1'b1});
    reset_n = 1'b0;
    #1;
    check("final_rst_err", rsp_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
